uart_wb_bridge: RTL and testbench
=================================

# uart_wb_bridge

UART-to-Wishbone debug initiator for zerosoc. It receives 8N1 command frames on a pad-level UART and issues single 32-bit Wishbone classic cycles on the SoC bus, so an external host can peek and poke SoC memory and peripherals. It answers each command over the UART transmit line. It sits beside the zerosoc core in the user project and drives one initiator port of the SoC interconnect.

## Interface
- BAUD_DIV, 104: clock cycles per UART bit; legal range 4..65535.
- TIMEOUT_CYCLES, 1024: cycles a bus cycle may wait for ack; only used with the timeout feature.
- clk_i  in  1  bridge clock; same clock as the SoC bus.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- uart_rx_i  in  1  serial input; idle high; asynchronous to clk_i.
- uart_tx_o  out  1  serial output; idle high.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  cycle acknowledge.
- busy_o  out  1  high in any state other than IDLE, ADDR or DATA.

## Operation
- **RX path:**
  - uart_rx_i passes through a 2-flop synchroniser.
  - A high-to-low edge starts a frame; the line is sampled at BAUD_DIV/2 and re-sampled every BAUD_DIV cycles after that.
  - Bits are received LSB first.
  - A start bit that reads 1 at mid-bit is a glitch; the receiver returns to idle.
  - A stop bit of 0 discards the byte and sends the parser to IDLE.
- **Parser states:** IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: byte 0x57 ('W') goes to ADDR with we=1; byte 0x52 ('R') goes to ADDR with we=0; any other byte is ignored.
  - ADDR: takes 4 bytes, MSB first, into wbm_adr_o. After the 4th byte it goes to DATA if we=1, else to BUS.
  - DATA: takes 4 bytes, MSB first, into wbm_dat_o, then goes to BUS.
  - BUS: cyc, stb and we are driven and wbm_sel_o=4'hF. The state is held until wbm_ack_i=1. Read data is captured on the ack edge, then the state goes to RESP.
  - RESP: a write sends 1 byte, 0x4B ('K'). A read sends 4 data bytes, MSB first. The state returns to IDLE when the last stop bit completes.
- **TX frame:** 1 start bit, 8 data bits LSB first, 1 stop bit, each BAUD_DIV cycles. Response bytes are sent back to back with no idle gap.
- Bytes received in BUS or RESP are dropped.
- The receiver keeps running in all states, so frame alignment is never lost.
- Addresses pass through unaligned; the bridge does no alignment checking.

## Timing
- **Reset values:**
  - uart_tx_o=1.
  - wbm_cyc_o, wbm_stb_o and wbm_we_o = 0.
  - wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0.
  - busy_o=0; parser in IDLE.
  - Reset asserted mid-cycle drops cyc and stb immediately, without waiting for a clock edge.
- **Bus cycle start:** cyc and stb rise on the first edge after the final command byte's stop-bit sample.
- **Bus cycle end:** on the edge where wbm_ack_i=1 is sampled, cyc and stb fall and wbm_sel_o returns to 0. A 1-cycle ack therefore gives a 2-cycle bus cycle.
- **Response start:** the response start bit begins on the edge after the ack edge.
- wbm_adr_o and wbm_dat_o are stable from cyc rising until ack.
- wbm_ack_i while cyc=0 is ignored.

## Configuration
- Macro: UART_WB_BRIDGE_TIMEOUT_EN.
- **Defined:**
  - A counter runs in BUS and clears on entry.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, cyc and stb drop on the next edge.
  - The bridge then sends the single byte 0x45 ('E') for both reads and writes, and no read data.
  - An ack arriving on the same edge as the timeout wins, giving the normal response.
- **Not defined:** BUS waits for ack indefinitely; no counter logic is synthesised.

## Structure
- **Package uart_wb_bridge_pkg:**
  - Constants CMD_WRITE=8'h57, CMD_READ=8'h52, RSP_OK=8'h4B, RSP_ERR=8'h45.
  - Parser state enum.
- **Sub-module uart_wb_bridge_rx:**
  - Contents: synchroniser, bit-timing counter, shifter.
  - Outputs: byte_o[7:0], a 1-cycle valid_o and a 1-cycle frame_err_o.
- The TX shifter and parser stay in the top module.

## Test plan
All scenarios use BAUD_DIV=8.
- **Write:** host sends 57 10 00 00 04 DE AD BE EF. Expect one cycle with adr=0x10000004, dat=0xDEADBEEF, we=1, sel=F; ack after 3 cycles; tx byte 0x4B.
- **Read:** host sends 52 20 00 00 00; responder returns 0x12345678 with ack. Expect tx bytes 12 34 56 78 back to back, and exactly one cycle with we=0.
- **Framing:**
  - Garbage byte 0x00, then a frame with stop bit 0 inside an address sequence: parser returns to IDLE and no bus cycle occurs.
  - A following valid write then completes normally.
- **Busy drop:** bytes 57 01 sent during RESP. They are ignored; the bridge is in IDLE afterwards and busy_o falls after the last stop bit.
- **Reset:** rst_ni asserted while cyc=1. cyc, stb and we go low with no clock edge; uart_tx_o=1.
- **Timeout (with UART_WB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16):** read with no ack. cyc drops after 16 cycles; tx byte 0x45 only.

Source files
------------

// File: rtl/uart_wb_bridge_pkg.sv
// rtl/uart_wb_bridge_pkg.sv - protocol bytes and parser state for the UART-to-Wishbone bridge
package uart_wb_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

  // Busy covers the bus cycle and the reply; command collection is not busy.
  function automatic logic is_busy(input state_e st);
    return !(st inside {ST_IDLE, ST_ADDR, ST_DATA});
  endfunction

endpackage

// File: rtl/uart_wb_bridge_rx.sv
// rtl/uart_wb_bridge_rx.sv - 8N1 receiver: synchroniser, mid-bit sampling, LSB-first shifter
module uart_wb_bridge_rx #(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(BAUD_DIV - 1);

  logic [1:0]  sync_q, sync_d;
  logic        prev_q, prev_d;
  rx_state_e   st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], rx_i};
    prev_d  = rx_s;
    st_d    = st_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that has recovered by mid-bit was only a glitch.
          st_d  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          st_d = RX_IDLE;
          if (rx_s) begin
            valid_d = 1'b1;
            byte_d  = sh_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign byte_o      = byte_q;
  assign valid_o     = valid_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/uart_wb_bridge.sv
// rtl/uart_wb_bridge.sv - UART command parser, Wishbone initiator and reply transmitter
// Optional ack timeout with error reply: define UART_WB_BRIDGE_TIMEOUT_EN.
module uart_wb_bridge #(
  parameter int unsigned BAUD_DIV = 104
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  import uart_wb_bridge_pkg::*;

  localparam logic [15:0] FULL_LAST = 16'(BAUD_DIV - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  uart_wb_bridge_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (uart_rx_i),
    .byte_o      (rx_byte),
    .valid_o     (rx_valid),
    .frame_err_o (rx_err)
  );

  state_e      state_q;
  logic        we_cmd_q;
  logic [1:0]  bcnt_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        cyc_q;
  logic        stb_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] rsp_sh_q;
  logic [2:0]  rsp_left_q;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q;
`endif

  logic [9:0]  tx_frame_q, tx_frame_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        tx_busy_q, tx_busy_d;
  logic        tx_end;
  logic        tx_load;

  // The next reply byte is loaded as the previous stop bit ends, so bytes go out back to back.
  assign tx_end  = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cnt_q == FULL_LAST);
  assign tx_load = (state_q == ST_RESP) && (rsp_left_q != 3'd0) && (!tx_busy_q || tx_end);

  always_comb begin
    tx_frame_d = tx_frame_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_busy_d  = tx_busy_q;
    if (tx_load) begin
      tx_frame_d = {1'b1, rsp_sh_q[31:24], 1'b0};
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_busy_d  = 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == FULL_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = tx_bit_q + 4'd1;
        tx_frame_d = {1'b1, tx_frame_q[9:1]};
        if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
      end else begin
        tx_cnt_d = tx_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_frame_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_frame_q <= tx_frame_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      we_cmd_q   <= 1'b0;
      bcnt_q     <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      rsp_sh_q   <= '0;
      rsp_left_q <= '0;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          bcnt_q <= '0;
          if (rx_valid && (rx_byte == CMD_WRITE || rx_byte == CMD_READ)) begin
            we_cmd_q <= (rx_byte == CMD_WRITE);
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (rx_err) begin
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            adr_q  <= {adr_q[23:0], rx_byte};
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              if (we_cmd_q) begin
                state_q <= ST_DATA;
              end else begin
                state_q <= ST_BUS;
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
                we_q    <= 1'b0;
                sel_q   <= 4'hF;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
                to_cnt_q <= '0;
`endif
              end
            end
          end
        end
        ST_DATA: begin
          if (rx_err) begin
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            dat_q  <= {dat_q[23:0], rx_byte};
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              state_q <= ST_BUS;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b1;
              sel_q   <= 4'hF;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end
          end
        end
        ST_BUS: begin
          if (wbm_ack_i) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            state_q    <= ST_RESP;
            rsp_sh_q   <= we_q ? {RSP_OK, 24'h0} : wbm_dat_i;
            rsp_left_q <= we_q ? 3'd1 : 3'd4;
          end
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            state_q    <= ST_RESP;
            rsp_sh_q   <= {RSP_ERR, 24'h0};
            rsp_left_q <= 3'd1;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
`endif
        end
        ST_RESP: begin
          if (tx_load) begin
            rsp_sh_q   <= {rsp_sh_q[23:0], 8'h00};
            rsp_left_q <= rsp_left_q - 3'd1;
          end else if (tx_end) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign uart_tx_o = tx_frame_q[0];
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign busy_o    = is_busy(state_q);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb/tb_uart_wb_bridge.sv - scoreboard bench for uart_wb_bridge with randomized peek/poke traffic
module tb_uart_wb_bridge;

  localparam int B = 8;

  logic        clk, rst_n, rx, tx;
  logic        cyc, stb, we, ack, busy;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int bus_seen = 0;
  int ack_delay = 0;
  bit no_ack = 0;

  typedef struct { logic [7:0] b; bit b2b; } tx_exp_t;
  typedef struct { logic [31:0] adr; logic [31:0] dat; bit we; int len; } bus_exp_t;
  tx_exp_t  tx_q[$];
  bus_exp_t bus_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];

  uart_wb_bridge #(
    .BAUD_DIV(B)
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(rx), .uart_tx_o(tx),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy_o(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'h5A5AA5A5;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    if (slave_mem.exists(a)) return slave_mem[a];
    return a ^ 32'h5A5AA5A5;
  endfunction

  // Wishbone responder: ack after ack_delay cycles of cyc, spurious acks while idle.
  initial begin
    int cnt;
    cnt = 0;
    ack = 0;
    dat_i = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ack = 0;
        cnt = 0;
      end else if (cyc && stb) begin
        ack = !no_ack && (cnt == ack_delay);
        dat_i = $urandom;
        if (ack) begin
          if (we) slave_mem[adr] = dat_o;
          else dat_i = slave_read(adr);
        end
        cnt++;
      end else begin
        cnt = 0;
        ack = ($urandom_range(0, 7) == 0);
        dat_i = $urandom;
      end
    end
  end

  // Bus monitor
  initial begin
    bus_exp_t e;
    int len;
    bit stable, acked;
    forever begin
      @(negedge clk);
      if (rst_n && cyc) begin
        bus_seen++;
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", 32'd1, 32'd0);
          e = '{adr: adr, dat: dat_o, we: we, len: 0};
        end else begin
          e = bus_q.pop_front();
          chk("bus_adr", adr, e.adr);
          chk("bus_we", {31'd0, we}, {31'd0, e.we});
          chk("bus_sel", {28'd0, sel}, 32'hF);
          chk("bus_stb", {31'd0, stb}, 32'd1);
          if (e.we) chk("bus_dat", dat_o, e.dat);
        end
        len = 0;
        stable = 1;
        acked = 0;
        while (cyc) begin
          len++;
          if (adr !== e.adr || we !== e.we || (e.we && dat_o !== e.dat)) stable = 0;
          if (ack) acked = 1;
          @(negedge clk);
        end
        if (rst_n) begin
          chk("bus_len", len, e.len);
          chk("bus_stable", {31'd0, stable}, 32'd1);
          chk("sel_end", {28'd0, sel}, 32'd0);
          if (acked) begin
            chk("rsp_hold", {31'd0, tx}, 32'd1);
            @(negedge clk);
            chk("rsp_start", {31'd0, tx}, 32'd0);
          end
        end
      end
    end
  end

  // UART transmit monitor
  initial begin
    tx_exp_t e;
    logic [7:0] b;
    logic stop;
    int st, last_st;
    last_st = 0;
    forever begin
      @(negedge clk);
      if (rst_n && !tx) begin
        st = cyc_n;
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = tx;
        end
        repeat (B) @(negedge clk);
        stop = tx;
        if (tx_q.size() == 0) begin
          chk("tx_unexpected", {24'd0, b}, 32'hFFFFFFFF);
        end else begin
          e = tx_q.pop_front();
          chk("tx_byte", {24'd0, b}, {24'd0, e.b});
          chk("tx_stop", {31'd0, stop}, 32'd1);
          if (e.b2b) chk("tx_gap", st - last_st, 10 * B);
        end
        last_st = st;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop = 1);
    @(negedge clk);
    rx = 0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (B) @(negedge clk);
    end
    rx = stop;
    repeat (B) @(negedge clk);
    rx = 1;
    if (!stop) repeat (B) @(negedge clk);
  endtask

  task automatic send_cmd(input bit w, input logic [31:0] a, input logic [31:0] d);
    send_byte(w ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
    if (w) for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_q.size() != 0 || bus_q.size() != 0 || busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, n < 6000}, 32'd1);
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input int dly, input bit wait_done);
    logic [31:0] r;
    bus_q.push_back('{adr: a, dat: d, we: w, len: dly + 1});
    if (w) begin
      tx_q.push_back('{b: 8'h4B, b2b: 0});
      ref_mem[a] = d;
    end else begin
      r = ref_read(a);
      for (int i = 0; i < 4; i++) tx_q.push_back('{b: r[31-8*i -: 8], b2b: (i != 0)});
    end
    ack_delay = dly;
    send_cmd(w, a, d);
    if (wait_done) wait_idle();
  endtask

  initial begin
    int n, seen0;
    logic [31:0] pool[4];
    rx = 1;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1;
    repeat (5) @(negedge clk);

    issue(1, 32'h10000004, 32'hDEADBEEF, 3, 1);

    slave_mem[32'h20000000] = 32'h12345678;
    ref_mem[32'h20000000] = 32'h12345678;
    issue(0, 32'h20000000, 32'h0, 0, 1);

    // Short low pulse that must not start a frame
    @(negedge clk);
    rx = 0;
    repeat (2) @(negedge clk);
    rx = 1;
    repeat (2 * B) @(negedge clk);

    seen0 = bus_seen;
    send_byte(8'h00);
    send_byte(8'h52);
    send_byte(8'h10);
    send_byte(8'h20, 0);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (4 * B) @(negedge clk);
    chk("no_bus_cycle", bus_seen, seen0);
    chk("idle_after_err", {31'd0, busy}, 32'd0);
    issue(1, 32'h00000100, 32'hCAFEF00D, 0, 1);

    issue(0, 32'h10000004, 32'h0, 2, 0);
    n = 0;
    while ((bus_q.size() != 0 || cyc) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("resp_reached", {31'd0, n < 3000}, 32'd1);
    send_byte(8'h57);
    send_byte(8'h01);
    chk("busy_in_resp", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("busy_dropped", {31'd0, busy}, 32'd0);

    pool[0] = 32'h00000100;
    pool[1] = 32'h10000004;
    pool[2] = 32'h80000003;
    pool[3] = $urandom;
    for (int i = 0; i < 18; i++) begin
      issue($urandom_range(0, 1), pool[$urandom_range(0, 3)], $urandom,
            $urandom_range(0, 5), 1);
    end

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    no_ack = 1;
    bus_q.push_back('{adr: 32'h30000000, dat: 32'h0, we: 0, len: 16});
    tx_q.push_back('{b: 8'h45, b2b: 0});
    send_cmd(0, 32'h30000000, 32'h0);
    wait_idle();
    no_ack = 0;
`endif

    no_ack = 1;
    bus_q.push_back('{adr: 32'h00000040, dat: 32'h11223344, we: 1, len: 0});
    send_cmd(1, 32'h00000040, 32'h11223344);
    n = 0;
    while (!cyc && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reset_cyc_seen", {31'd0, cyc}, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("async_cyc", {31'd0, cyc}, 32'd0);
    chk("async_stb", {31'd0, stb}, 32'd0);
    chk("async_we", {31'd0, we}, 32'd0);
    chk("async_tx", {31'd0, tx}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1;
    no_ack = 0;
    repeat (20 * B) @(negedge clk);
    chk("sb_empty", tx_q.size() + bus_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
